// File: rtl/btn_pkg.sv
// btn_pkg: shared types and sizing helpers for the push-button conditioner
// (btn_channel, btn_conditioner_if, btn_conditioner).
package btn_pkg;

  // Per-channel debounce FSM. The encoding is also exported on the debug bus.
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } btn_state_t;

  // Largest of three integers.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // One counter width covers debounce, first-repeat delay and repeat period,
  // so every terminal value fits.
  function automatic int cnt_width(input int deb, input int rdly, input int rper);
    return $clog2(max3(deb, rdly, rper) + 1);
  endfunction

  // Width of the press_code index (at least one bit for a single channel).
  function automatic int code_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// btn_conditioner_if: pad-side and event-side signals of the button conditioner.
//
// Signal contract: there is no backpressure. btn_raw is an asynchronous level
// from the pads. btn_press / btn_release / btn_repeat / any_press are one-cycle
// pulses that a consumer must take on the cycle they are high; press_code is
// only meaningful while any_press is high and reads 0 otherwise. btn_level is
// the debounced level. dbg_state carries each channel's FSM state, two bits per
// channel, channel 0 in the low bits.
interface btn_conditioner_if #(
  parameter int NUM_BTN = 5
);
  localparam int CODE_W = btn_pkg::code_width(NUM_BTN);

  logic [NUM_BTN-1:0]   btn_raw;
  logic [NUM_BTN-1:0]   btn_level;
  logic [NUM_BTN-1:0]   btn_press;
  logic [NUM_BTN-1:0]   btn_release;
  logic [NUM_BTN-1:0]   btn_repeat;
  logic                 any_press;
  logic [CODE_W-1:0]    press_code;
  logic [2*NUM_BTN-1:0] dbg_state;

  // Board / stimulus side drives the pads and observes the events.
  modport master (
    output btn_raw,
    input  btn_level, btn_press, btn_release, btn_repeat,
    input  any_press, press_code, dbg_state
  );

  // Conditioner side.
  modport slave (
    input  btn_raw,
    output btn_level, btn_press, btn_release, btn_repeat,
    output any_press, press_code, dbg_state
  );
endinterface

// File: rtl/btn_channel.sv
// btn_channel: one button channel -- synchroniser, debounce FSM and, when
// BTN_AUTOREPEAT_EN is defined, the auto-repeat timer. All outputs registered;
// press_next_o is the combinational next value of press_o so the parent can
// register its encoder in the same cycle as the pulse.
module btn_channel
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 5000000,
  parameter int REPEAT_PERIOD   = 1000000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       raw_i,
  output logic       level_o,
  output logic       press_o,
  output logic       release_o,
  output logic       repeat_o,
  output logic       press_next_o,
  output btn_state_t state_o
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             level_q, level_d;
  logic             acc_press_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  // Synchroniser chain: raw pad shifts in at bit 0, s is the oldest stage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Debounce FSM next state: a change is accepted after DEBOUNCE_CYCLES
  // consecutive samples that differ from the current level. The debounce
  // counter only advances up to DEB_LAST, where acceptance happens.
  always_comb begin
    state_d     = state_q;
    deb_cnt_d   = deb_cnt_q;
    level_d     = level_q;
    acc_press_d = 1'b0;
    release_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d     = HELD;
            level_d     = 1'b1;
            acc_press_d = 1'b1;
          end else begin
            state_d   = DEB_PRESS;
            deb_cnt_d = CNT_ONE;
          end
        end
      end
      DEB_PRESS: begin
        if (!s) begin
          // Bounce: back to idle, nothing reported.
          state_d   = IDLE;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d     = HELD;
          deb_cnt_d   = '0;
          level_d     = 1'b1;
          acc_press_d = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d   = IDLE;
            level_d   = 1'b0;
            release_d = 1'b1;
          end else begin
            state_d   = DEB_RELEASE;
            deb_cnt_d = CNT_ONE;
          end
        end
      end
      DEB_RELEASE: begin
        if (s) begin
          // Bounce back: still held, repeat timing carries on undisturbed.
          state_d   = HELD;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d   = IDLE;
          deb_cnt_d = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d   = IDLE;
        deb_cnt_d = '0;
        level_d   = 1'b0;
      end
    endcase
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [CNT_W-1:0] rep_last;
  logic             rep_armed_q, rep_armed_d;
  logic             repeat_q, repeat_d;

  // Repeat timer: runs only while the level stays 1 across the edge (HELD or
  // DEB_RELEASE on both sides). It restarts at press acceptance and is cleared
  // on accepted release, which also swallows a repeat due on that same edge.
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_armed_d = rep_armed_q;
    repeat_d    = 1'b0;
    rep_last    = rep_armed_q ? PER_LAST : DLY_LAST;
    if (level_q && level_d) begin
      if (rep_cnt_q == rep_last) begin
        rep_cnt_d   = '0;
        rep_armed_d = 1'b1;
        repeat_d    = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + CNT_ONE;
      end
    end else begin
      rep_cnt_d   = '0;
      rep_armed_d = 1'b0;
    end
  end

  // Repeat timer and repeat pulse registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rep_cnt_q   <= '0;
      rep_armed_q <= 1'b0;
      repeat_q    <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_armed_q <= rep_armed_d;
      repeat_q    <= repeat_d;
    end
  end

  assign press_d  = acc_press_d | repeat_d;
  assign repeat_o = repeat_q;
`else
  assign press_d  = acc_press_d;
  assign repeat_o = 1'b0;
`endif

  // FSM state, debounce counter and registered event outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      deb_cnt_q <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      deb_cnt_q <= deb_cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o      = level_q;
  assign press_o      = press_q;
  assign release_o    = release_q;
  assign press_next_o = press_d;
  assign state_o      = state_q;

endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: NUM_BTN independent button channels plus a registered
// any_press / press_code encoder aligned with btn_press.
// Optional auto-repeat is enabled by defining BTN_AUTOREPEAT_EN.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int NUM_BTN         = 5,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 5000000,
  parameter int REPEAT_PERIOD   = 1000000
) (
  input  logic               hwclk,
  input  logic               reset,
  btn_conditioner_if.slave   bus
);

  localparam int CODE_W = code_width(NUM_BTN);

  logic [NUM_BTN-1:0]   level_w;
  logic [NUM_BTN-1:0]   press_w;
  logic [NUM_BTN-1:0]   release_w;
  logic [NUM_BTN-1:0]   repeat_w;
  logic [NUM_BTN-1:0]   press_next_w;
  logic [2*NUM_BTN-1:0] state_w;

  logic                 any_press_q;
  logic [CODE_W-1:0]    press_code_q, press_code_d;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    btn_state_t ch_state;

    btn_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_channel (
      .clk_i       (hwclk),
      .rst_ni      (reset),
      .raw_i       (bus.btn_raw[g]),
      .level_o     (level_w[g]),
      .press_o     (press_w[g]),
      .release_o   (release_w[g]),
      .repeat_o    (repeat_w[g]),
      .press_next_o(press_next_w[g]),
      .state_o     (ch_state)
    );

    assign state_w[2*g +: 2] = ch_state;
  end

  // Priority encoder on next-cycle presses: lowest channel index wins.
  always_comb begin
    press_code_d = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (press_next_w[i]) begin
        press_code_d = CODE_W'(i);
      end
    end
  end

  // Register the encoder so it lines up with the registered btn_press.
  always_ff @(posedge hwclk or negedge reset) begin
    if (!reset) begin
      any_press_q  <= 1'b0;
      press_code_q <= '0;
    end else begin
      any_press_q  <= |press_next_w;
      press_code_q <= press_code_d;
    end
  end

  assign bus.btn_level   = level_w;
  assign bus.btn_press   = press_w;
  assign bus.btn_release = release_w;
  assign bus.btn_repeat  = repeat_w;
  assign bus.any_press   = any_press_q;
  assign bus.press_code  = press_code_q;
  assign bus.dbg_state   = state_w;

endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed scenarios plus random pad activity on a
// 4-channel conditioner (2 sync stages, debounce 4, repeat delay 10 / period 3).
// The reference model works from the behavioural rules: a pad value reaches
// the debouncer SYNC edges later, a level flips after DEB consecutive
// disagreeing samples, repeats fire at fixed ages after acceptance.
module tb_btn_conditioner;
  import btn_pkg::*;

  localparam int NB   = 4;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int RDLY = 10;
  localparam int RPER = 3;
  localparam int CW   = code_width(NB);
  localparam int OW   = 4 * NB + 1 + CW;
  localparam int LAT  = SYNC + DEB - 1;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic hwclk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 hwclk = ~hwclk;

  btn_conditioner_if #(.NUM_BTN(NB)) bus ();

  btn_conditioner #(
    .NUM_BTN        (NB),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RDLY),
    .REPEAT_PERIOD  (RPER)
  ) dut (
    .hwclk(hwclk),
    .reset(reset),
    .bus  (bus)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [NB-1:0] m_level;
  logic [NB-1:0] hist[$];
  int            m_run[NB];
  int            m_acc[NB];
  int            edge_no = 0;
  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] exp_w;

  function automatic logic [OW-1:0] obs();
    return {bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_repeat,
            bus.any_press, bus.press_code};
  endfunction

  task automatic model_reset();
    m_level = '0;
    hist.delete();
    for (int i = 0; i < SYNC; i++) hist.push_back('0);
    for (int i = 0; i < NB; i++) begin
      m_run[i] = 0;
      m_acc[i] = 0;
    end
    exp_q.delete();
  endtask

  // Drive the pads, take one clock edge, advance the model, sample at +1.
  task automatic tick(input logic [NB-1:0] raw);
    logic [NB-1:0] s, pr, rl, rp;
    logic [CW-1:0] code;
    int age;
    bus.btn_raw = raw;
    @(posedge hwclk);
    edge_no++;
    s = hist.pop_front();
    hist.push_back(raw);
    pr = '0; rl = '0; rp = '0;
    for (int i = 0; i < NB; i++) begin
      if (s[i] != m_level[i]) m_run[i]++;
      else m_run[i] = 0;
      if (m_run[i] == DEB) begin
        m_run[i]   = 0;
        m_level[i] = s[i];
        if (s[i]) begin
          pr[i]    = 1'b1;
          m_acc[i] = edge_no;
        end else begin
          rl[i] = 1'b1;
        end
      end else if (AR && m_level[i]) begin
        age = edge_no - m_acc[i];
        if (age == RDLY || (age > RDLY && (age - RDLY) % RPER == 0)) begin
          pr[i] = 1'b1;
          rp[i] = 1'b1;
        end
      end
    end
    code = '0;
    for (int i = NB - 1; i >= 0; i--) if (pr[i]) code = CW'(i);
    exp_q.push_back({m_level, pr, rl, rp, |pr, code});
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus.btn_raw = '0;
    model_reset();
    #2 reset = 1'b0;
    repeat (3) @(posedge hwclk);
    #1;
    checks++;
    if (obs() !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", obs());
    end
    checks++;
    if (bus.dbg_state !== '0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=0", bus.dbg_state);
    end
    reset = 1'b1;
  endtask

  task automatic settle(input int n);
    for (int k = 0; k < n; k++) begin
      tick('0);
      exp_w = exp_q.pop_front();
      checks++;
      if (obs() !== exp_w) begin
        failures++;
        $display("FAIL settle cyc=%0d got=%h exp=%h", k, obs(), exp_w);
      end
    end
  endtask

  task automatic test_single_press();
    for (int k = 0; k < 12; k++) begin
      tick(4'b0010);
      exp_w = exp_q.pop_front();
      checks++;
      if (obs() !== exp_w) begin
        failures++;
        $display("FAIL single_press_model cyc=%0d got=%h exp=%h", k, obs(), exp_w);
      end
      checks++;
      if (bus.btn_press !== ((k == LAT) ? 4'b0010 : 4'b0000)) begin
        failures++;
        $display("FAIL single_press_pulse cyc=%0d got=%b", k, bus.btn_press);
      end
      if (k == LAT) begin
        checks++;
        if (bus.press_code !== 2'd1 || bus.btn_level[1] !== 1'b1 || bus.any_press !== 1'b1) begin
          failures++;
          $display("FAIL single_press_code got code=%0d level=%b any=%b exp code=1 level=1 any=1",
                   bus.press_code, bus.btn_level[1], bus.any_press);
        end
      end
    end
  endtask

  task automatic test_release();
    for (int k = 0; k < 10; k++) begin
      tick(4'b0000);
      exp_w = exp_q.pop_front();
      checks++;
      if (obs() !== exp_w) begin
        failures++;
        $display("FAIL release_model cyc=%0d got=%h exp=%h", k, obs(), exp_w);
      end
      checks++;
      if (bus.btn_release !== ((k == LAT) ? 4'b0010 : 4'b0000) ||
          bus.btn_level[1] !== (k < LAT)) begin
        failures++;
        $display("FAIL release_pulse cyc=%0d got rel=%b lvl=%b", k, bus.btn_release, bus.btn_level[1]);
      end
    end
  endtask

  task automatic test_bounce();
    int n_press = 0;
    int n_rel = 0;
    for (int k = 0; k < 14; k++) begin
      tick({3'b000, (k != 3)});
      exp_w = exp_q.pop_front();
      checks++;
      if (obs() !== exp_w) begin
        failures++;
        $display("FAIL bounce_model cyc=%0d got=%h exp=%h", k, obs(), exp_w);
      end
      checks++;
      if (bus.btn_press[0] !== (k == 4 + LAT)) begin
        failures++;
        $display("FAIL bounce_pulse_time cyc=%0d got=%b exp=%b", k, bus.btn_press[0], (k == 4 + LAT));
      end
      n_press += int'(bus.btn_press[0]);
      n_rel   += int'(bus.btn_release[0]);
    end
    checks++;
    if (n_press != 1 || n_rel != 0) begin
      failures++;
      $display("FAIL bounce_count got press=%0d rel=%0d exp press=1 rel=0", n_press, n_rel);
    end
  endtask

  task automatic test_simultaneous();
    for (int k = 0; k < 10; k++) begin
      tick(4'b1100);
      exp_w = exp_q.pop_front();
      checks++;
      if (obs() !== exp_w) begin
        failures++;
        $display("FAIL simultaneous_model cyc=%0d got=%h exp=%h", k, obs(), exp_w);
      end
      if (k == LAT) begin
        checks++;
        if ({bus.btn_press, bus.any_press, bus.press_code} !== {4'b1100, 1'b1, 2'd2}) begin
          failures++;
          $display("FAIL simultaneous_pulse got press=%b any=%b code=%0d exp press=1100 any=1 code=2",
                   bus.btn_press, bus.any_press, bus.press_code);
        end
      end
    end
  endtask

  // Hold channel 0 for 25 edges, then let go; release accepted at edge 30,
  // where a repeat would otherwise be due.
  task automatic test_autorepeat();
    logic ep, er, el;
    for (int k = 0; k < 36; k++) begin
      tick((k < 25) ? 4'b0001 : 4'b0000);
      exp_w = exp_q.pop_front();
      checks++;
      if (obs() !== exp_w) begin
        failures++;
        $display("FAIL autorepeat_model cyc=%0d got=%h exp=%h", k, obs(), exp_w);
      end
      er = AR && (k inside {15, 18, 21, 24, 27});
      ep = (k == 5) || er;
      el = (k == 30);
      checks++;
      if ({bus.btn_press[0], bus.btn_repeat[0], bus.btn_release[0]} !== {ep, er, el}) begin
        failures++;
        $display("FAIL autorepeat_pulse cyc=%0d got p/r/rel=%b%b%b exp=%b%b%b", k,
                 bus.btn_press[0], bus.btn_repeat[0], bus.btn_release[0], ep, er, el);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 18; k++) begin
      tick({2'b00, 1'b1, (k >= 15)});
      exp_w = exp_q.pop_front();
      checks++;
      if (obs() !== exp_w) begin
        failures++;
        $display("FAIL reset_mid_pre cyc=%0d got=%h exp=%h", k, obs(), exp_w);
      end
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (obs() !== '0 || bus.dbg_state !== '0) begin
      failures++;
      $display("FAIL reset_mid_async got=%h state=%h exp=0", obs(), bus.dbg_state);
    end
    repeat (2) @(posedge hwclk);
    #2;
    model_reset();
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick(4'b0010);
      exp_w = exp_q.pop_front();
      checks++;
      if (obs() !== exp_w) begin
        failures++;
        $display("FAIL reset_mid_post cyc=%0d got=%h exp=%h", k, obs(), exp_w);
      end
      checks++;
      if (bus.btn_press !== ((k == LAT) ? 4'b0010 : 4'b0000)) begin
        failures++;
        $display("FAIL reset_mid_fresh cyc=%0d got=%b", k, bus.btn_press);
      end
    end
  endtask

  task automatic test_random();
    logic [NB-1:0] r = '0;
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < NB; i++) if ($urandom_range(0, 11) == 0) r[i] = ~r[i];
      tick(r);
      exp_w = exp_q.pop_front();
      checks++;
      if (obs() !== exp_w) begin
        failures++;
        $display("FAIL random cyc=%0d raw=%b got=%h exp=%h", k, r, obs(), exp_w);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.btn_raw = '0;
    test_reset();
    test_single_press();
    test_release();
    settle(8);
    test_bounce();
    settle(12);
    test_simultaneous();
    settle(12);
    test_autorepeat();
    settle(4);
    test_reset_mid();
    settle(12);
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
